// File: rtl/multi_way_switch.sv
`default_nettype none
// ============================================================================
// Module   : multi_way_switch
// Brief    : N-way light-switch controller. Synchronises and debounces N raw
//            switch inputs, combines them with a selectable function into a
//            registered lamp, applies an optional inactivity auto-off and
//            counts lamp transitions.
// Revision : 1.0 - initial release
// ============================================================================
module multi_way_switch #(
    parameter int N        = 4,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 1000,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  sw,
    input  logic [1:0]    mode,
    output logic          lamp,
    output logic          event_o,
    output logic [N-1:0]  db_o,
    output logic          timed_out,
    output logic [CW-1:0] toggle_cnt
);

    // Counter widths are kept at least one bit so DEBOUNCE=1 / TIMEOUT=0 still elaborate.
    localparam int DCW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DCW-1:0] C_DB_LAST = DCW'(DEBOUNCE - 1);
    localparam logic [TW-1:0]  C_T_LAST  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [1:0]     C_MODE_HOLD = 2'd3;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ON  = 2'd1,
        ST_TO  = 2'd2
    } state_t;

    logic [N-1:0]   r_s1;
    logic [N-1:0]   r_s2;
    logic [DCW-1:0] r_cnt [N];
    logic [N-1:0]   w_upd;
    logic           r_ev1;
    logic           w_func;
    logic           w_tmo;
    logic           w_lamp_next;
    logic [TW-1:0]  r_tcnt;
    logic [TW-1:0]  w_tcnt_next;
    state_t         r_state;
    state_t         w_next;

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw;
            r_s2 <= r_s1;
        end
    end

    // A bit is accepted on the edge where it has differed for DEBOUNCE cycles.
    always_comb begin
        w_upd = '0;
        for (int i = 0; i < N; i++) begin
            w_upd[i] = (r_s2[i] != db_o[i]) && (r_cnt[i] == C_DB_LAST);
        end
    end

    // Per-bit debounce counters; any return to the accepted level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_o <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r_s2[i] != db_o[i]) begin
                    if (r_cnt[i] == C_DB_LAST) begin
                        db_o[i]  <= r_s2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + DCW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Combining function; hold mode simply feeds the lamp back on itself.
    always_comb begin
        w_func = lamp;
        case (mode)
            2'd0:    w_func = ^db_o;
            2'd1:    w_func = &db_o;
            2'd2:    w_func = |db_o;
            default: w_func = lamp;
        endcase
    end

    // r_ev1 flags the db update one edge after it lands, so the lamp and
    // event_o react together on the edge after db_o changes.
    assign w_tmo = (TIMEOUT != 0) && (r_tcnt == C_T_LAST) && !r_ev1;

    // Lamp state machine next-state; hold mode freezes everything.
    always_comb begin
        w_next = r_state;
        if (mode != C_MODE_HOLD) begin
            case (r_state)
                ST_OFF: if (w_func) w_next = ST_ON;
                ST_ON: begin
                    if (!w_func)    w_next = ST_OFF;
                    else if (w_tmo) w_next = ST_TO;
                end
                ST_TO:   if (r_ev1) w_next = w_func ? ST_ON : ST_OFF;
                default: w_next = ST_OFF;
            endcase
        end
    end

    // Inactivity timer: counts only while staying in ON without an event.
    always_comb begin
        w_tcnt_next = r_tcnt;
        if (mode != C_MODE_HOLD) begin
            if ((r_state == ST_ON) && (w_next == ST_ON) && !r_ev1) begin
                w_tcnt_next = r_tcnt + TW'(1);
            end else begin
                w_tcnt_next = '0;
            end
        end
    end

    assign w_lamp_next = (w_next == ST_ON);

    // State, timer, event pipeline and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_tcnt     <= '0;
            r_ev1      <= 1'b0;
            event_o    <= 1'b0;
            lamp       <= 1'b0;
            timed_out  <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_tcnt    <= w_tcnt_next;
            r_ev1     <= |w_upd;
            event_o   <= r_ev1;
            lamp      <= w_lamp_next;
            timed_out <= (w_next == ST_TO);
            if (w_lamp_next != lamp) begin
                toggle_cnt <= toggle_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire
